ca2_sched: RTL and testbench
============================

# ca2_sched

Round-robin scheduler that shares a single two's-complement negation unit (R = −A with C/V/N/Z condition codes) among `n_req` requesters. Each granted operation latches the winner's operand, computes R in one cycle, then updates the four CCR flags in four further cycles (C, V, N, Z), and signals completion with a one-cycle `done`. It replaces the free-running, delay-based negation path with a clocked, arbitrated resource that the rest of the ALU datapath can request.

## Interface
- `op_size`, 4, operand and result width in bits
- `n_req`, 2, number of requesters (≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  n_req  per-requester request, level; hold until own `done`
- `a_in`  in  n_req*op_size  flattened operands; requester i in bits [i*op_size +: op_size]
- `gnt`  out  n_req  one-hot grant, registered, held for the whole operation
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse; R and CCR final
- `R`  out  op_size  result −A (mod 2^op_size)
- `CCR`  out  4  condition codes {C,V,N,Z}, bit 3 = C … bit 0 = Z

## Operation
- States: IDLE → CALC → FLAG_C → FLAG_V → FLAG_N → FLAG_Z → DONE → IDLE.
- IDLE: if `req` ≠ 0, pick winner w = first set bit searching from `ptr` upward with wrap; latch `a_reg` ← operand w; `gnt` ← onehot(w); `ptr` ← (w+1) mod n_req; go to CALC. If `req` = 0, stay; outputs hold.
- CALC: R ← −a_reg (op_size bits, wrap).
- FLAG_C: CCR[3] ← (a_reg ≠ 0) (borrow from 0−A).
- FLAG_V: CCR[2] ← (a_reg ≠ 0 && a_reg == R), i.e. a_reg = 100…0.
- FLAG_N: CCR[1] ← R[op_size−1].
- FLAG_Z: CCR[0] ← (R == 0).
- Each flag state writes only its bit; others keep previous values (CCR is visible evolving mid-operation).
- DONE: `done` = 1, `gnt` still held; next edge → IDLE, `gnt` ← 0.
- Operand latched once; changes on `a_in` or drop of `req` after the grant edge do not affect the running operation, which always completes.
- Requester keeping `req` high after `done` re-competes in IDLE; round-robin guarantees alternation under continuous contention.

## Timing
- Reset values: state IDLE, `gnt` 0, `busy` 0, `done` 0, `R` 0, `CCR` 0000, `ptr` 0, `a_reg` 0.
- Reset asserts asynchronously at any state, aborts the operation (no `done`); first edge after deassert is evaluated in IDLE.
- Edge k (IDLE, req seen) → `gnt`/`busy` high from k. R valid after k+1; C after k+2; V after k+3; N after k+4; Z and `done` after k+5; `gnt`, `busy`, `done` low after k+6.
- Latency request-sample edge → `done` = 5 cycles; throughput one operation per 7 cycles (IDLE occupies one cycle between operations).
- `done`, `gnt`, `busy` are register outputs; no combinational path from `req`/`a_in` to any output.

## Structure
- Package `ca2_pkg`: state enum (7 states), CCR bit indices C=3, V=2, N=1, Z=0, and masks 4'b1000/0100/0010/0001.
- One sub-module: `rr_pick`, combinational round-robin picker (inputs `req`, `ptr`; outputs one-hot winner, index, valid), parameterised by `n_req`.
- Negation and flag logic stay inline in `ca2_sched`.

## Test plan
- Req0 only, A0=0011 → `gnt`=01, `done` 5 cycles after sampling edge, R=1101, CCR=1010; intermediate CCR values show one bit changing per cycle.
- Req1 only, A1=0000 → R=0000, CCR=0001; A1=1000 next → R=1000, CCR=1110 (C, V, N set).
- After reset, req=11 held continuously, A0=0001, A1=0111 → grants 01,10,01,10; results R=1111/CCR=1010 and R=1001/CCR=1010 alternating; 7 cycles per operation.
- During operation for requester 0, change A0 to 0101 and drop req0 at FLAG_C → operation completes with originally latched operand, `done` still pulses.
- Assert `rst_n`=0 during FLAG_V → R, CCR, `gnt`, `busy`, `done` go 0 immediately; after release, req=11 grants requester 0 first (ptr reset).
- Single requester back-to-back, req0 held, A0=0111 → successive `done` pulses 7 cycles apart, R=1001, CCR=1010 each time.

Source files
------------

// File: rtl/ca2_pkg.sv
// Shared types and constants for the arbitrated two's-complement negation unit.
// CCR layout is {C,V,N,Z}; flags are written one bit per cycle using the masks below.
package ca2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_FLAG_C,
        ST_FLAG_V,
        ST_FLAG_N,
        ST_FLAG_Z,
        ST_DONE
    } state_t;

    localparam int CCR_C = 3;
    localparam int CCR_V = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    localparam logic [3:0] CCR_C_MASK = 4'b1000;
    localparam logic [3:0] CCR_V_MASK = 4'b0100;
    localparam logic [3:0] CCR_N_MASK = 4'b0010;
    localparam logic [3:0] CCR_Z_MASK = 4'b0001;

    // Writes a single flag while leaving the other CCR bits untouched.
    function automatic logic [3:0] ccr_put(input logic [3:0] ccr, input logic [3:0] mask,
                                           input logic val);
        return val ? (ccr | mask) : (ccr & ~mask);
    endfunction

endpackage

// File: rtl/ca2_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, with wrap.
module rr_pick #(
    parameter int n_req = 2,
    localparam int IDX_W = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic [n_req-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [n_req-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int cand;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int off = 0; off < n_req; off++) begin
            cand = (int'(ptr) + off) % n_req;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ca2_sched.sv
// Round-robin shared negation unit: R = -A, then C, V, N, Z flags one per cycle,
// finishing with a one-cycle done pulse while the grant is still held.
module ca2_sched
    import ca2_pkg::*;
#(
    parameter int op_size = 4,
    parameter int n_req   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [n_req-1:0]           req,
    input  logic [n_req*op_size-1:0]   a_in,
    output logic [n_req-1:0]           gnt,
    output logic                       busy,
    output logic                       done,
    output logic [op_size-1:0]         R,
    output logic [3:0]                 CCR
);

    localparam int IDX_W = (n_req > 1) ? $clog2(n_req) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_ptr;
    logic [op_size-1:0]   r_a;
    logic [op_size-1:0]   r_r;
    logic [3:0]           r_ccr;
    logic [n_req-1:0]     r_gnt;
    logic                 r_busy;
    logic                 r_done;

    logic [op_size-1:0]   w_ops [n_req];
    logic [n_req-1:0]     w_winner;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_valid;
    logic [IDX_W-1:0]     w_ptr_next;

    generate
        for (genvar gi = 0; gi < n_req; gi++) begin : g_ops
            assign w_ops[gi] = a_in[gi*op_size +: op_size];
        end
    endgenerate

    rr_pick #(.n_req(n_req)) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .idx    (w_idx),
        .valid  (w_valid)
    );

    assign w_ptr_next = (w_idx == IDX_W'(n_req - 1)) ? '0 : w_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_state_next = ST_CALC;
            ST_CALC:   w_state_next = ST_FLAG_C;
            ST_FLAG_C: w_state_next = ST_FLAG_V;
            ST_FLAG_V: w_state_next = ST_FLAG_N;
            ST_FLAG_N: w_state_next = ST_FLAG_Z;
            ST_FLAG_Z: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Operand is captured only at the grant edge; later a_in/req changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_a    <= '0;
            r_r    <= '0;
            r_ccr  <= '0;
            r_gnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_valid) begin
                    r_a    <= w_ops[w_idx];
                    r_gnt  <= w_winner;
                    r_ptr  <= w_ptr_next;
                    r_busy <= 1'b1;
                end
                ST_CALC:   r_r   <= '0 - r_a;
                ST_FLAG_C: r_ccr <= ccr_put(r_ccr, CCR_C_MASK, r_a != '0);
                // Only 100..0 negates to itself among nonzero values.
                ST_FLAG_V: r_ccr <= ccr_put(r_ccr, CCR_V_MASK, (r_a != '0) && (r_a == r_r));
                ST_FLAG_N: r_ccr <= ccr_put(r_ccr, CCR_N_MASK, r_r[op_size-1]);
                ST_FLAG_Z: begin
                    r_ccr  <= ccr_put(r_ccr, CCR_Z_MASK, r_r == '0);
                    r_done <= 1'b1;
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign done = r_done;
    assign R    = r_r;
    assign CCR  = r_ccr;

endmodule

// File: tb/tb_ca2_sched.sv
// Directed bench for ca2_sched: hand-computed negation results and CCR sequences.
module tb_ca2_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] a_in;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [3:0] R;
    logic [3:0] CCR;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_ccr;

    ca2_sched #(.op_size(4), .n_req(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a_in  (a_in),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .CCR   (CCR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs one operation from the grant edge through the return to IDLE (7 edges).
    // Optionally changes req/a_in while the unit sits in FLAG_C.
    task automatic run_op(input string tag, input logic [1:0] eg, input logic [3:0] er,
                          input logic [3:0] ec, input logic mod_en,
                          input logic [1:0] mreq, input logic [7:0] ma);
        tick();
        chk({tag, " gnt"}, gnt, eg);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " done0"}, done, 0);
        tick();
        chk({tag, " R"}, R, er);
        chk({tag, " ccr_calc"}, CCR, exp_ccr);
        if (mod_en) begin
            req  = mreq;
            a_in = ma;
        end
        tick();
        exp_ccr[3] = ec[3];
        chk({tag, " ccr_c"}, CCR, exp_ccr);
        tick();
        exp_ccr[2] = ec[2];
        chk({tag, " ccr_v"}, CCR, exp_ccr);
        tick();
        exp_ccr[1] = ec[1];
        chk({tag, " ccr_n"}, CCR, exp_ccr);
        chk({tag, " done_early"}, done, 0);
        tick();
        exp_ccr[0] = ec[0];
        chk({tag, " ccr_final"}, CCR, ec);
        chk({tag, " done"}, done, 1);
        chk({tag, " R_final"}, R, er);
        chk({tag, " gnt_held"}, gnt, eg);
        tick();
        chk({tag, " done_low"}, done, 0);
        chk({tag, " gnt_low"}, gnt, 0);
        chk({tag, " busy_low"}, busy, 0);
        $display("[TB] %s gnt=%b R=%b CCR=%b", tag, eg, R, CCR);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        a_in    = 8'h00;
        exp_ccr = 4'b0000;
        #12;
        chk("rst gnt", gnt, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst R", R, 0);
        chk("rst CCR", CCR, 0);

        // Req0 only, A0=0011
        req  = 2'b01;
        a_in = {4'h0, 4'b0011};
        rst_n = 1'b1;
        run_op("t1_a0_3", 2'b01, 4'b1101, 4'b1010, 1'b0, 2'b00, 8'h00);

        // Req1 only, A1=0000 then A1=1000 back-to-back
        req  = 2'b10;
        a_in = {4'b0000, 4'h0};
        run_op("t2_a1_0", 2'b10, 4'b0000, 4'b0001, 1'b0, 2'b00, 8'h00);
        a_in = {4'b1000, 4'h0};
        run_op("t2_a1_8", 2'b10, 4'b1000, 4'b1110, 1'b0, 2'b00, 8'h00);

        // Continuous contention alternates grants
        req  = 2'b11;
        a_in = {4'b0111, 4'b0001};
        run_op("t3_op0", 2'b01, 4'b1111, 4'b1010, 1'b0, 2'b00, 8'h00);
        run_op("t3_op1", 2'b10, 4'b1001, 4'b1010, 1'b0, 2'b00, 8'h00);
        run_op("t3_op2", 2'b01, 4'b1111, 4'b1010, 1'b0, 2'b00, 8'h00);
        run_op("t3_op3", 2'b10, 4'b1001, 4'b1010, 1'b0, 2'b00, 8'h00);

        // Operand change and req drop mid-operation are ignored
        req  = 2'b01;
        a_in = {4'h0, 4'b0011};
        run_op("t4_latched", 2'b01, 4'b1101, 4'b1010, 1'b1, 2'b00, {4'h0, 4'b0101});
        tick();
        chk("t4 no_regrant", gnt, 0);
        chk("t4 idle_busy", busy, 0);

        // Reset during FLAG_V aborts; pointer returns to requester 0
        req  = 2'b01;
        a_in = {4'b0111, 4'b0001};
        tick();
        chk("t5 gnt", gnt, 2'b01);
        tick();
        chk("t5 R", R, 4'b1111);
        tick();
        chk("t5 ccr_c", CCR[3], 1);
        rst_n = 1'b0;
        #1;
        chk("t5 rst R", R, 0);
        chk("t5 rst CCR", CCR, 0);
        chk("t5 rst gnt", gnt, 0);
        chk("t5 rst busy", busy, 0);
        chk("t5 rst done", done, 0);
        $display("[TB] t5 reset in FLAG_V gnt=%b R=%b CCR=%b", gnt, R, CCR);
        exp_ccr = 4'b0000;
        @(negedge clk);
        req   = 2'b11;
        rst_n = 1'b1;
        run_op("t5_after_rst", 2'b01, 4'b1111, 4'b1010, 1'b0, 2'b00, 8'h00);

        // Single requester back-to-back
        req  = 2'b01;
        a_in = {4'h0, 4'b0111};
        run_op("t6_op0", 2'b01, 4'b1001, 4'b1010, 1'b0, 2'b00, 8'h00);
        run_op("t6_op1", 2'b01, 4'b1001, 4'b1010, 1'b0, 2'b00, 8'h00);
        req = 2'b00;
        tick();
        chk("t6 idle_gnt", gnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
